bconv_stream_layer: RTL



---
 rtl/bconv_stream_layer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bconv_stream_layer.sv
// Streaming binary convolution layer.
// Takes a binarised feature map one pixel per beat in row-major order, builds a
// K_H x K_W window from line buffers, and emits one N_CH-bit thresholded
// XNOR-popcount result per valid window position.
// Optional build macro BCONV_POPCOUNT_OUT_EN adds the out_popcount port.
module bconv_stream_layer #(
  parameter int INPUT_H = 28,
  parameter int INPUT_W = 28,
  parameter int K_H     = 3,
  parameter int K_W     = 3,
  parameter int N_CH    = 4,
  localparam int PC_W   = $clog2(K_H*K_W+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_pixel,
  input  logic [N_CH*K_H*K_W-1:0] kernels,
  input  logic [PC_W-1:0]         thresh,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH-1:0]         out_pixel,
`ifdef BCONV_POPCOUNT_OUT_EN
  output logic [N_CH*PC_W-1:0]    out_popcount,
`endif
  output logic                    frame_done
);

  localparam int OUTPUT_H = INPUT_H - K_H + 1;
  localparam int OUTPUT_W = INPUT_W - K_W + 1;
  localparam int KN       = K_H * K_W;
  localparam int ROW_W    = $clog2(INPUT_H);
  localparam int COL_W    = $clog2(INPUT_W);

  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [KN-1:0]      win;
  logic [KN-1:0]      win_nxt;
  // lb[0] holds row r-1, lb[K_H-2] holds row r-K_H+1
  logic [INPUT_W-1:0] lb [K_H-1];
  logic               accept;
  logic               gen;
  logic               last_pos;
  logic               out_last;
  logic [PC_W-1:0]    pc [N_CH];
  logic [N_CH-1:0]    pix_nxt;
  logic [N_CH*PC_W-1:0] pc_flat;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign gen      = (row >= ROW_W'(K_H-1)) && (col >= COL_W'(K_W-1));
  // the bottom-right window position is the last output of the frame
  assign last_pos = (row == ROW_W'(OUTPUT_H+K_H-2)) && (col == COL_W'(OUTPUT_W+K_W-2));

  // Window after the current pixel: shift left, new right column from line buffers + input
  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < K_H; i++) begin
      for (int j = 0; j < K_W-1; j++) begin
        win_nxt[i*K_W+j] = win[i*K_W+j+1];
      end
    end
    for (int i = 0; i < K_H-1; i++) begin
      win_nxt[i*K_W+K_W-1] = lb[K_H-2-i][col];
    end
    win_nxt[KN-1] = in_pixel;
  end

  // XNOR-popcount per channel and unsigned threshold compare
  always_comb begin
    pix_nxt = '0;
    pc_flat = '0;
    for (int n = 0; n < N_CH; n++) begin
      pc[n] = '0;
      for (int b = 0; b < KN; b++) begin
        pc[n] = pc[n] + {{(PC_W-1){1'b0}}, ~(win_nxt[b] ^ kernels[n*KN+b])};
      end
      pix_nxt[n] = (pc[n] >= thresh);
      pc_flat[n*PC_W +: PC_W] = pc[n];
    end
  end

  // Line buffer: per-column shift of the last K_H-1 rows; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col] <= in_pixel;
      for (int k = 1; k < K_H-1; k++) begin
        lb[k][col] <= lb[k-1][col];
      end
    end
  end

  // Position counters, window, single-entry output register and frame_done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      win        <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        win <= win_nxt;
        if (col == COL_W'(INPUT_W-1)) begin
          col <= '0;
          row <= (row == ROW_W'(INPUT_H-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (gen) begin
          out_valid <= 1'b1;
          out_pixel <= pix_nxt;
          out_last  <= last_pos;
        end
      end
    end
  end

`ifdef BCONV_POPCOUNT_OUT_EN
  // Popcount output register, loaded together with out_pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_popcount <= '0;
    end else if (accept && gen) begin
      out_popcount <= pc_flat;
    end
  end
`endif

endmodule
